// File: rtl/pio_poll_sequencer.sv
// Avalon-MM master that polls a button PIO on a fixed tick, debounces bit 0 and
// writes an incrementing press counter to an LED PIO. All bus outputs are
// registered from the next state so they are clean from the first edge.
module pio_poll_sequencer #(
  parameter int unsigned            ADDR_W         = 8,
  parameter logic [ADDR_W-1:0]      BTN_BASE       = 'h00,
  parameter logic [ADDR_W-1:0]      LED_BASE       = 'h10,
  parameter int unsigned            LED_W          = 8,
  parameter int unsigned            POLL_DIV       = 50000,
  parameter int unsigned            DEBOUNCE_N     = 4,
  parameter bit                     BTN_ACTIVE_LOW = 1'b1,
  parameter int unsigned            TIMEOUT        = 255
) (
  input  logic              clk_clk_clk,
  input  logic              reset_reset,
  input  logic              enable,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [LED_W-1:0]  led_value,
  output logic              btn_level,
  output logic              press_pulse,
  output logic              bus_error,
  output logic              busy
);

  localparam int unsigned DivW = $clog2(POLL_DIV);

  typedef enum logic [2:0] {StInit, StIdle, StRd, StEval, StWr} state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [7:0]        to_cnt_q, to_cnt_d;
  logic [3:0]        deb_cnt_q, deb_cnt_d;
  logic              btn_level_q, btn_level_d;
  logic              sample_q, sample_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              bus_err_q, bus_err_d;
  logic              busy_q, busy_d;

  logic              tick;
  logic              accept;
  logic              stall;
  logic              timeout;
  logic              raw_pressed;
  logic [LED_W-1:0]  led_inc;
  logic              unused_readdata;

  // Only bit 0 of the button register matters.
  assign unused_readdata = ^avm_readdata[31:1];

  assign raw_pressed = avm_readdata[0] ^ BTN_ACTIVE_LOW;
  assign led_inc     = led_q + LED_W'(1);

  // Request bookkeeping: acceptance, stall and timeout detection.
  always_comb begin
    accept  = (read_q | write_q) & ~avm_waitrequest;
    stall   = (read_q | write_q) & avm_waitrequest;
    timeout = stall & (to_cnt_q == 8'(TIMEOUT - 1));
    tick    = (div_q == DivW'(POLL_DIV - 1));
    div_d   = tick ? '0 : div_q + DivW'(1);
    to_cnt_d = (stall && !timeout) ? to_cnt_q + 8'd1 : 8'd0;
  end

  // Next-state, debounce, LED counter and registered bus request decode.
  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    btn_level_d = btn_level_q;
    sample_d    = sample_q;
    led_d       = led_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    press_pulse = 1'b0;
    bus_err_d   = bus_err_q;

    // A timeout in the same cycle as err_clr keeps the flag set.
    if (err_clr) bus_err_d = 1'b0;
    if (timeout) bus_err_d = 1'b1;

    case (state_q)
      StInit: begin
        if (accept) begin
          led_d   = '0;
          state_d = StIdle;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (tick && enable) state_d = StRd;
      end
      StRd: begin
        if (accept) begin
          sample_d = raw_pressed;
          state_d  = StEval;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StEval: begin
        state_d = StIdle;
        if (sample_q == btn_level_q) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q + 4'd1 == 4'(DEBOUNCE_N)) begin
          deb_cnt_d   = '0;
          btn_level_d = sample_q;
          if (sample_q) begin
            press_pulse = 1'b1;
            wdata_d     = 32'(led_inc);
            state_d     = StWr;
          end
        end else begin
          deb_cnt_d = deb_cnt_q + 4'd1;
        end
      end
      StWr: begin
        if (accept) begin
          led_d   = wdata_q[LED_W-1:0];
          state_d = StIdle;
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StInit;
    endcase

    read_d  = (state_d == StRd);
    write_d = (state_d == StInit) || (state_d == StWr);
    busy_d  = (state_d != StIdle);
    if (state_d == StRd) addr_d = BTN_BASE;
    if (write_d)         addr_d = LED_BASE;
    if (state_d == StInit) wdata_d = '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_clk_clk) begin
    if (reset_reset) begin
      state_q     <= StInit;
      div_q       <= '0;
      to_cnt_q    <= '0;
      deb_cnt_q   <= '0;
      btn_level_q <= 1'b0;
      sample_q    <= 1'b0;
      led_q       <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bus_err_q   <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      to_cnt_q    <= to_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      btn_level_q <= btn_level_d;
      sample_q    <= sample_d;
      led_q       <= led_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bus_err_q   <= bus_err_d;
      busy_q      <= busy_d;
    end
  end

  assign avm_address   = addr_q;
  assign avm_read      = read_q;
  assign avm_write     = write_q;
  assign avm_writedata = wdata_q;
  assign led_value     = led_q;
  assign btn_level     = btn_level_q;
  assign bus_error     = bus_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_pio_poll_sequencer.sv
// Bench for pio_poll_sequencer: a simple stallable PIO slave, a scoreboard of
// expected LED writes popped by a bus monitor, and directed button sequences.
module tb_pio_poll_sequencer;

  localparam int unsigned POLL_DIV = 4;
  localparam int unsigned TIMEOUT  = 255;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        err_clr;
  logic [7:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [7:0]  led_value;
  logic        btn_level;
  logic        press_pulse;
  logic        bus_error;
  logic        busy;

  logic        btn_raw;
  int          wr_stall;
  int          rd_stall;
  int          stall_ctr = 0;
  int          cyc = 0;
  int          total;
  int          bad;

  logic [39:0] exp_q[$];
  logic [39:0] exp_e;
  logic [7:0]  exp_led;

  int          rd_cnt = 0;
  int          pp_cnt = 0;
  int          wr_len = 0;
  int          last_wr_len = 0;
  int          rd_start = 0;
  int          prev_rd_start = 0;
  int          pp_cyc = 0;
  int          wr_start = 0;
  logic        rd_prev = 1'b0;
  logic [7:0]  prev_addr;
  logic [31:0] prev_data;

  pio_poll_sequencer #(
    .POLL_DIV(POLL_DIV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_clk_clk    (clk),
    .reset_reset    (rst),
    .enable         (enable),
    .err_clr        (err_clr),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .led_value      (led_value),
    .btn_level      (btn_level),
    .press_pulse    (press_pulse),
    .bus_error      (bus_error),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: stall each request for a programmable number of cycles.
  assign avm_readdata    = {31'b0, btn_raw};
  assign avm_waitrequest = (avm_write && (stall_ctr < wr_stall)) ||
                           (avm_read && (stall_ctr < rd_stall));

  always @(posedge clk) begin
    if ((avm_read || avm_write) && avm_waitrequest) stall_ctr <= stall_ctr + 1;
    else stall_ctr <= 0;
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on accepted writes, tracks reads and pulses.
  always @(negedge clk) begin
    if (press_pulse === 1'b1) begin
      pp_cnt++;
      pp_cyc = cyc;
    end
    if (avm_read === 1'b1 || avm_write === 1'b1)
      check("rd_wr_exclusive", 40'(avm_read & avm_write), 40'(0));
    if (avm_read === 1'b1) begin
      if (!rd_prev) begin
        prev_rd_start = rd_start;
        rd_start      = cyc;
      end
      if (avm_waitrequest === 1'b0) rd_cnt++;
    end
    rd_prev = (avm_read === 1'b1);
    if (avm_write === 1'b1) begin
      if (wr_len == 0) begin
        wr_start = cyc;
      end else begin
        check("wr_addr_hold", 40'(avm_address), 40'(prev_addr));
        check("wr_data_hold", 40'(avm_writedata), 40'(prev_data));
      end
      wr_len++;
      prev_addr = avm_address;
      prev_data = avm_writedata;
      if (avm_waitrequest === 1'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got %0h expected none", {avm_address, avm_writedata});
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_txn", {avm_address, avm_writedata}, exp_e);
        end
        last_wr_len = wr_len;
        wr_len      = 0;
      end
    end else if (wr_len != 0) begin
      last_wr_len = wr_len;
      wr_len      = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_reads(input int n);
    int target;
    int k;
    target = rd_cnt + n;
    k = 0;
    while (rd_cnt < target && k < 200 * n) begin
      tick();
      k++;
    end
    check("wait_reads_bound", 40'(rd_cnt >= target), 40'(1));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 1000) begin
      tick();
      k++;
    end
    check("wait_idle_bound", 40'(busy), 40'(0));
  endtask

  task automatic do_polls(input logic raw, input int n);
    btn_raw = raw;
    wait_reads(n);
    wait_idle();
  endtask

  initial begin
    int k;
    int n;
    total = 0;
    bad = 0;
    rst = 1'b1;
    enable = 1'b0;
    err_clr = 1'b0;
    btn_raw = 1'b1;
    wr_stall = 0;
    rd_stall = 0;
    exp_led = 8'h00;

    // Reset values, then the INIT write of 0 to the LED PIO.
    exp_q.push_back({8'h10, 32'h0});
    repeat (3) tick();
    check("rst_read", 40'(avm_read), 40'(0));
    check("rst_write", 40'(avm_write), 40'(0));
    check("rst_addr", 40'(avm_address), 40'(0));
    check("rst_wdata", 40'(avm_writedata), 40'(0));
    check("rst_led", 40'(led_value), 40'(0));
    check("rst_btn", 40'(btn_level), 40'(0));
    check("rst_pulse", 40'(press_pulse), 40'(0));
    check("rst_err", 40'(bus_error), 40'(0));
    check("rst_busy", 40'(busy), 40'(1));
    rst = 1'b0;
    tick();
    check("init_write", 40'(avm_write), 40'(1));
    check("init_addr", 40'(avm_address), 40'(8'h10));
    check("init_data", 40'(avm_writedata), 40'(0));
    tick();
    check("init_busy", 40'(busy), 40'(0));
    check("init_write_drop", 40'(avm_write), 40'(0));
    check("init_led", 40'(led_value), 40'(0));

    // Held press: accepted on the 4th poll, one write of 1.
    enable = 1'b1;
    exp_led = 8'h01;
    exp_q.push_back({8'h10, 32'h1});
    do_polls(1'b0, 3);
    check("deb_3_btn", 40'(btn_level), 40'(0));
    check("deb_3_led", 40'(led_value), 40'(0));
    do_polls(1'b0, 1);
    check("deb_4_btn", 40'(btn_level), 40'(1));
    check("press_led", 40'(led_value), 40'(1));
    check("press_count", 40'(pp_cnt), 40'(1));
    check("read_to_pulse", 40'(pp_cyc - rd_start), 40'(1));
    check("pulse_to_write", 40'(wr_start - pp_cyc), 40'(1));
    do_polls(1'b0, 3);
    check("held_led", 40'(led_value), 40'(1));
    check("held_pulses", 40'(pp_cnt), 40'(1));
    do_polls(1'b1, 3);
    check("rel_3_btn", 40'(btn_level), 40'(1));
    do_polls(1'b1, 1);
    check("rel_4_btn", 40'(btn_level), 40'(0));
    check("rel_led", 40'(led_value), 40'(1));

    // Glitches shorter than the debounce window are rejected.
    do_polls(1'b0, 3);
    do_polls(1'b1, 1);
    do_polls(1'b0, 3);
    check("glitch_btn", 40'(btn_level), 40'(0));
    do_polls(1'b1, 1);
    check("glitch_pulses", 40'(pp_cnt), 40'(1));
    check("glitch_led", 40'(led_value), 40'(1));

    // 256 clean presses: counter passes through FF -> 00.
    for (int i = 0; i < 256; i++) begin
      exp_led = exp_led + 8'd1;
      exp_q.push_back({8'h10, 24'h0, exp_led});
      do_polls(1'b0, 4);
      check("wrap_led", 40'(led_value), 40'(exp_led));
      do_polls(1'b1, 4);
    end
    check("wrap_pulses", 40'(pp_cnt), 40'(257));

    // LED write stalled 5 cycles: held 6 cycles then accepted.
    wr_stall = 5;
    exp_led = exp_led + 8'd1;
    exp_q.push_back({8'h10, 24'h0, exp_led});
    do_polls(1'b0, 4);
    check("stall_len", 40'(last_wr_len), 40'(6));
    check("stall_led", 40'(led_value), 40'(exp_led));
    check("stall_err", 40'(bus_error), 40'(0));
    wr_stall = 0;
    do_polls(1'b1, 4);

    // LED write never accepted: dropped after TIMEOUT cycles, press lost.
    wr_stall = 100000;
    do_polls(1'b0, 4);
    tick();
    check("to_len", 40'(last_wr_len), 40'(TIMEOUT));
    check("to_err", 40'(bus_error), 40'(1));
    check("to_led", 40'(led_value), 40'(exp_led));
    check("to_btn", 40'(btn_level), 40'(1));
    wr_stall = 0;
    do_polls(1'b0, 2);
    check("to_no_retry_led", 40'(led_value), 40'(exp_led));
    check("err_sticky", 40'(bus_error), 40'(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", 40'(bus_error), 40'(0));
    do_polls(1'b1, 4);
    check("to_rel_btn", 40'(btn_level), 40'(0));

    // Disable during a stalled read: read completes, polling stops.
    rd_stall = 6;
    k = 0;
    while (avm_read !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check("rd_stall_seen", 40'(avm_read), 40'(1));
    enable = 1'b0;
    n = rd_cnt;
    wait_idle();
    check("rd_completed", 40'(rd_cnt), 40'(n + 1));
    repeat (40) tick();
    check("no_reads_disabled", 40'(rd_cnt), 40'(n + 1));

    // Re-enabled with zero-wait reads: one read every POLL_DIV cycles.
    rd_stall = 0;
    enable = 1'b1;
    wait_reads(3);
    check("poll_period_a", 40'(rd_start - prev_rd_start), 40'(POLL_DIV));
    wait_reads(1);
    check("poll_period_b", 40'(rd_start - prev_rd_start), 40'(POLL_DIV));

    // Reset while the LED write is stalled, then INIT write of 0.
    wr_stall = 50;
    btn_raw = 1'b0;
    k = 0;
    while (avm_write !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check("wr_seen", 40'(avm_write), 40'(1));
    rst = 1'b1;
    enable = 1'b0;
    tick();
    check("rst_wr_drop", 40'(avm_write), 40'(0));
    check("rst_wr_led", 40'(led_value), 40'(0));
    wr_stall = 0;
    exp_q.push_back({8'h10, 32'h0});
    rst = 1'b0;
    tick();
    check("reinit_write", 40'(avm_write), 40'(1));
    check("reinit_data", 40'(avm_writedata), 40'(0));
    tick();
    check("reinit_busy", 40'(busy), 40'(0));
    check("reinit_led", 40'(led_value), 40'(0));
    check("reinit_btn", 40'(btn_level), 40'(0));
    repeat (2) tick();
    check("sb_empty", 40'(exp_q.size()), 40'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
